// File: rtl/tdm_pkg.sv
// Shared types and constants for the three-slot TDM receive path.
package tdm_pkg;

  localparam int NUM_SLOTS = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_frame_counter.sv
// Bit-position counter within a TDM frame: 0..NUM_SLOTS*WIDTH-1, wrapping.
module tdm_frame_counter
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int N  = NUM_SLOTS * WIDTH,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load1,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          is_first,
  output logic          is_last
);

  assign is_first = (idx == '0);
  assign is_last  = (idx == IW'(N - 1));

  // clear beats load1 beats inc; inc wraps from the last bit back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      idx <= '0;
    else if (clear)  idx <= '0;
    else if (load1)  idx <= IW'(1);
    else if (inc)    idx <= is_last ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/tdm_demux3.sv
// Three-channel TDM receiver: frame alignment FSM, serial-to-parallel
// assembly and per-slot output registers.
module tdm_demux3
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             din,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int N  = NUM_SLOTS * WIDTH;
  localparam int IW = $clog2(N);

  state_t                              state, state_nxt;
  logic   [IW-1:0]                     idx;
  logic                                is_first, is_last;
  logic                                cnt_clear, cnt_load1, cnt_inc;
  logic                                shift_en, frame_done, err_nxt;
  logic   [N-2:0]                      sr;
  logic   [N-1:0]                      frame;
  logic   [NUM_SLOTS-1:0][WIDTH-1:0]   q_r;

  tdm_frame_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .load1    (cnt_load1),
    .inc      (cnt_inc),
    .idx      (idx),
    .is_first (is_first),
    .is_last  (is_last)
  );

  // Bit 0 lands in the MSB of the assembled frame, so slot 0 is the top word.
  assign frame = {sr, din};

  // Alignment decisions for the bit sampled this cycle
  always_comb begin
    state_nxt  = state;
    cnt_clear  = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      HUNT: begin
        if (sync) begin
          shift_en  = 1'b1;
          cnt_load1 = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (is_first) begin
          if (sync) begin
            shift_en  = 1'b1;
            cnt_load1 = 1'b1;
          end else begin
            // expected frame start did not come: drop the bit and re-hunt
            err_nxt   = 1'b1;
            cnt_clear = 1'b1;
            state_nxt = HUNT;
          end
        end else if (sync) begin
          // early sync restarts the frame on this very bit
          err_nxt   = 1'b1;
          shift_en  = 1'b1;
          cnt_load1 = 1'b1;
        end else begin
          shift_en   = 1'b1;
          cnt_inc    = 1'b1;
          frame_done = is_last;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Serial assembly of bits 0..N-2; the final bit is taken straight from din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sr <= '0;
    else if (shift_en) sr <= {sr[N-3:0], din};
  end

  // Status pulses and lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= err_nxt;
      if (err_nxt)         locked <= 1'b0;
      else if (frame_done) locked <= 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    // Per-slot output word, reloaded only on a completed frame
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          q_r[s] <= '0;
      else if (frame_done) q_r[s] <= frame[N-1-s*WIDTH -: WIDTH];
    end
  end

  assign q0 = q_r[0];
  assign q1 = q_r[1];
  assign q2 = q_r[2];

endmodule
